// File: rtl/nco_pkg.sv
// Shared definitions for the NCO waveform generator: output modes, pipeline
// latency and the quarter-wave sine table contents.
package nco_pkg;

   typedef enum logic [1:0] {
      MODE_SINE   = 2'd0,
      MODE_SQUARE = 2'd1,
      MODE_SAW    = 2'd2,
      MODE_TRI    = 2'd3
   } nco_mode_e;

   localparam int NCO_LAT = 3;

   // Entry idx of a quarter-wave table sampled at bin centres, amplitude 2^(out_w-1)-1.
   function automatic int nco_rom_entry(input int idx, input int out_w, input int lut_aw);
      real amp;
      real ang;
      amp = (2.0 ** (out_w - 1)) - 1.0;
      ang = 3.14159265358979 / 2.0 * (real'(idx) + 0.5) / (2.0 ** lut_aw);
      return $rtoi(amp * $sin(ang) + 0.5);
   endfunction

endpackage

// File: rtl/nco_sine_rom.sv
// Quarter-wave sine ROM with a registered read; the magnitude arrives one
// cycle after the address.
module nco_sine_rom
   import nco_pkg::*;
#(
   parameter int OUT_W  = 8,
   parameter int LUT_AW = 6
) (
   input  logic              clk,
   input  logic [LUT_AW-1:0] addr_i,
   output logic [OUT_W-2:0]  q_o
);

   logic [OUT_W-2:0] rom_tbl [2**LUT_AW];
   logic [OUT_W-2:0] q_q;

   generate
      for (genvar gi = 0; gi < 2**LUT_AW; gi++) begin : g_rom
         assign rom_tbl[gi] = (OUT_W-1)'(nco_rom_entry(gi, OUT_W, LUT_AW));
      end
   endgenerate

   always_ff @(posedge clk) begin
      q_q <= rom_tbl[addr_i];
   end

   assign q_o = q_q;

endmodule

// File: rtl/nco_wavegen.sv
// Phase accumulator with shadowed tuning word feeding a three-stage waveform
// pipeline (phase register, ROM/arithmetic stage, output register).
module nco_wavegen
   import nco_pkg::*;
#(
   parameter int ACC_W  = 16,
   parameter int OUT_W  = 8,
   parameter int LUT_AW = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             fcw_wr,
   input  logic [ACC_W-1:0] fcw,
   input  logic [ACC_W-1:0] phase_off,
   input  logic [1:0]       mode,
   input  logic             sync_clr,
   output logic             fcw_busy,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid,
   output logic             wrap
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] fcw_act_q, fcw_act_d;
   logic [ACC_W-1:0] fcw_pend_q, fcw_pend_d;
   logic             busy_q, busy_d;
   logic             wrap_src_q, wrap_src_d;
   logic [ACC_W:0]   sum;
   logic             apply;

   // The pending word lands on a carry, an idle cycle or a sync clear so the
   // frequency change never tears a phase ramp mid-cycle.
   always_comb begin
      sum        = {1'b0, acc_q} + {1'b0, fcw_act_q};
      apply      = sync_clr | ~en | sum[ACC_W];
      acc_d      = acc_q;
      wrap_src_d = 1'b0;
      if (sync_clr) begin
         acc_d      = '0;
         wrap_src_d = 1'b1;
      end else if (en) begin
         acc_d      = sum[ACC_W-1:0];
         wrap_src_d = sum[ACC_W];
      end
      fcw_act_d  = apply ? fcw_pend_q : fcw_act_q;
      fcw_pend_d = fcw_wr ? fcw : fcw_pend_q;
      busy_d     = fcw_wr | (busy_q & ~apply);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q      <= '0;
         fcw_act_q  <= '0;
         fcw_pend_q <= '0;
         busy_q     <= 1'b0;
         wrap_src_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         fcw_act_q  <= fcw_act_d;
         fcw_pend_q <= fcw_pend_d;
         busy_q     <= busy_d;
         wrap_src_q <= wrap_src_d;
      end
   end

   assign fcw_busy = busy_q;

   // S1: offset phase and per-sample controls
   logic [ACC_W-1:0] p1_q;
   nco_mode_e        mode1_q;
   logic             v1_q, w1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_q    <= '0;
         mode1_q <= MODE_SINE;
         v1_q    <= 1'b0;
         w1_q    <= 1'b0;
      end else begin
         p1_q    <= acc_q + phase_off;
         mode1_q <= nco_mode_e'(mode);
         v1_q    <= en;
         w1_q    <= wrap_src_q;
      end
   end

   logic [1:0]        quad1;
   logic [LUT_AW-1:0] addr1;
   logic [OUT_W-1:0]  ph1;
   logic [OUT_W-1:0]  arith1;
   logic              unused_p;

   assign quad1    = p1_q[ACC_W-1:ACC_W-2];
   assign addr1    = p1_q[ACC_W-3 -: LUT_AW] ^ {LUT_AW{quad1[0]}};
   assign ph1      = p1_q[ACC_W-1 -: OUT_W];
   assign unused_p = ^p1_q;

   always_comb begin
      case (mode1_q)
         MODE_SQUARE: arith1 = ph1[OUT_W-1] ? '0 : '1;
         MODE_TRI:    arith1 = {ph1[OUT_W-2:0], 1'b0} ^ {OUT_W{ph1[OUT_W-1]}};
         default:     arith1 = ph1;
      endcase
   end

   // S2: ROM read alongside the arithmetic waveforms
   logic [OUT_W-2:0] rom_q;
   logic [OUT_W-1:0] arith2_q;
   nco_mode_e        mode2_q;
   logic             neg2_q, v2_q, w2_q;

   nco_sine_rom #(.OUT_W(OUT_W), .LUT_AW(LUT_AW)) u_rom (
      .clk    (clk),
      .addr_i (addr1),
      .q_o    (rom_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         arith2_q <= '0;
         mode2_q  <= MODE_SINE;
         neg2_q   <= 1'b0;
         v2_q     <= 1'b0;
         w2_q     <= 1'b0;
      end else begin
         arith2_q <= arith1;
         mode2_q  <= mode1_q;
         neg2_q   <= quad1[1];
         v2_q     <= v1_q;
         w2_q     <= w1_q;
      end
   end

   // Offset-binary sine: half+q on the upper half-wave, half-1-q on the lower.
   logic [OUT_W-1:0] sample_d;
   always_comb begin
      if (mode2_q == MODE_SINE)
         sample_d = neg2_q ? {1'b0, ~rom_q} : {1'b1, rom_q};
      else
         sample_d = arith2_q;
   end

   // S3: output register
   logic [OUT_W-1:0] sample_q;
   logic             valid_q, wrap_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_q <= '0;
         valid_q  <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         sample_q <= sample_d;
         valid_q  <= v2_q;
         wrap_q   <= w2_q;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign wrap         = wrap_q;

endmodule

// File: tb/tb_nco_wavegen.sv
// Bench for nco_wavegen: an arithmetic phase/waveform model checked every
// cycle, plus directed sequences pinned to hand-computed sample values.
module tb_nco_wavegen;
   import nco_pkg::*;

   localparam int ACC_W  = 16;
   localparam int OUT_W  = 8;
   localparam int LUT_AW = 6;
   localparam int AMASK  = (1 << ACC_W) - 1;
   localparam int HALF   = 1 << (OUT_W - 1);

   logic             clk = 1'b0;
   logic             rst, en, fcw_wr, sync_clr;
   logic [ACC_W-1:0] fcw, phase_off;
   logic [1:0]       mode;
   logic             fcw_busy, sample_valid, wrap;
   logic [OUT_W-1:0] sample;

   always #5 clk = ~clk;

   nco_wavegen #(.ACC_W(ACC_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .fcw_wr       (fcw_wr),
      .fcw          (fcw),
      .phase_off    (phase_off),
      .mode         (mode),
      .sync_clr     (sync_clr),
      .fcw_busy     (fcw_busy),
      .sample       (sample),
      .sample_valid (sample_valid),
      .wrap         (wrap)
   );

   int n_cmp = 0;
   int n_err = 0;
   int got_s[$];
   bit got_w[$];
   bit started = 1'b0;

   typedef struct {
      bit v;
      bit w;
      int s;
      bit chk;
   } slot_t;

   slot_t pipe [NCO_LAT];
   int    m_acc, m_act, m_pend;
   bit    m_busy, m_wflag;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Waveform value straight from the phase, using plain arithmetic.
   function automatic int exp_sample(input int p, input int md);
      int ph, quad, addr, q;
      ph = (p >> (ACC_W - OUT_W)) & ((1 << OUT_W) - 1);
      case (md)
         0: begin
            quad = (p >> (ACC_W - 2)) & 3;
            addr = (p >> (ACC_W - 2 - LUT_AW)) & ((1 << LUT_AW) - 1);
            if (quad % 2 == 1) addr = (1 << LUT_AW) - 1 - addr;
            q = nco_rom_entry(addr, OUT_W, LUT_AW);
            return (quad < 2) ? HALF + q : HALF - 1 - q;
         end
         1: return (ph < HALF) ? (1 << OUT_W) - 1 : 0;
         2: return ph;
         default: return (ph < HALF) ? 2 * ph : 2 * (1 << OUT_W) - 1 - 2 * ph;
      endcase
   endfunction

   // Compare what the last edge produced, then advance the model with the
   // inputs the next edge will sample.
   initial begin
      int  sum;
      bit  carry, apply;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("valid", int'(sample_valid), int'(pipe[NCO_LAT-1].v));
            chk("wrap", int'(wrap), int'(pipe[NCO_LAT-1].w));
            chk("busy", int'(fcw_busy), int'(m_busy));
            if (pipe[NCO_LAT-1].chk) chk("sample", int'(sample), pipe[NCO_LAT-1].s);
            if (sample_valid) begin
               got_s.push_back(int'(sample));
               got_w.push_back(wrap);
            end
         end
         started = 1'b1;
         if (rst) begin
            for (int i = 0; i < NCO_LAT; i++) pipe[i] = '{1'b0, 1'b0, 0, 1'b0};
            pipe[NCO_LAT-1].chk = 1'b1;
            m_acc = 0; m_act = 0; m_pend = 0; m_busy = 1'b0; m_wflag = 1'b0;
         end else begin
            for (int i = NCO_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{bit'(en), m_wflag,
                        exp_sample((m_acc + int'(phase_off)) & AMASK, int'(mode)), bit'(en)};
            sum   = m_acc + m_act;
            carry = (sum > AMASK);
            apply = sync_clr || !en || carry;
            if (sync_clr) begin
               m_acc = 0; m_wflag = 1'b1;
            end else if (en) begin
               m_acc = sum & AMASK; m_wflag = carry;
            end else begin
               m_wflag = 1'b0;
            end
            if (apply) begin
               m_act = m_pend; m_busy = 1'b0;
            end
            if (fcw_wr) begin
               m_pend = int'(fcw); m_busy = 1'b1;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      got_s.delete();
      got_w.delete();
   endtask

   // Load a word while idle, zero the accumulator and let the pipeline drain.
   task automatic prog(input int f, input int md);
      en = 1'b0; mode = 2'(md); sync_clr = 1'b1; fcw_wr = 1'b1; fcw = ACC_W'(f);
      cyc();
      sync_clr = 1'b0; fcw_wr = 1'b0;
      repeat (4) cyc();
      clear_log();
   endtask

   task automatic check_seq(input string name, input int exp_s [8], input int n);
      if (got_s.size() < n) begin
         n_cmp++; n_err++;
         $display("FAIL %s_count: got %0d samples expected %0d", name, got_s.size(), n);
      end else begin
         for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", name, i), got_s[i], exp_s[i]);
      end
   endtask

   task automatic check_at(input string name, input int idx, input int exp_s, input int exp_w);
      if (got_s.size() <= idx) begin
         n_cmp++; n_err++;
         $display("FAIL %s_count: got %0d samples expected > %0d", name, got_s.size(), idx);
      end else begin
         chk($sformatf("%s_s", name), got_s[idx], exp_s);
         chk($sformatf("%s_w", name), int'(got_w[idx]), exp_w);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; fcw_wr = 1'b0; fcw = '0; sync_clr = 1'b0;
      phase_off = '0; mode = 2'd0;
      cyc(); cyc();
      chk("rst_sample", int'(sample), 0);
      chk("rst_valid", int'(sample_valid), 0);
      chk("rst_busy", int'(fcw_busy), 0);
      chk("rst_wrap", int'(wrap), 0);

      rst = 1'b0; en = 1'b1; clear_log();
      repeat (6) cyc();
      check_seq("zero_fcw_sine", '{130, 130, 130, 0, 0, 0, 0, 0}, 3);
      check_at("zero_fcw_nowrap", 0, 130, 0);

      prog(16'h4000, 0);
      en = 1'b1; repeat (12) cyc(); en = 1'b0;
      check_seq("sine_quad", '{130, 255, 125, 0, 130, 255, 125, 0}, 8);
      check_at("sine_wrap", 4, 130, 1);

      prog(16'h0100, 2);
      en = 1'b1; repeat (262) cyc(); en = 1'b0;
      check_at("saw_0", 0, 0, 0);
      check_at("saw_1", 1, 1, 0);
      check_at("saw_128", 128, 128, 0);
      check_at("saw_255", 255, 255, 0);
      check_at("saw_wrap", 256, 0, 1);

      prog(16'h2000, 1);
      en = 1'b1; repeat (12) cyc(); en = 1'b0;
      check_seq("square", '{255, 255, 255, 255, 0, 0, 0, 0}, 8);

      prog(16'h2000, 3);
      en = 1'b1; repeat (12) cyc(); en = 1'b0;
      check_seq("triangle", '{0, 64, 128, 192, 255, 191, 127, 63}, 8);

      // Shadowed tuning word lands only on the carry.
      prog(16'h4000, 0);
      en = 1'b1; cyc();
      fcw_wr = 1'b1; fcw = 16'h8000; cyc(); fcw_wr = 1'b0;
      chk("shadow_busy_8000", int'(fcw_busy), 1);
      cyc();
      chk("shadow_busy_c000", int'(fcw_busy), 1);
      cyc();
      chk("shadow_busy_applied", int'(fcw_busy), 0);
      cyc();
      fcw_wr = 1'b1; fcw = 16'h4000; cyc(); fcw_wr = 1'b0;
      chk("shadow_busy_wr_on_wrap", int'(fcw_busy), 1);
      cyc();
      chk("shadow_busy_held", int'(fcw_busy), 1);
      en = 1'b0; cyc();
      chk("shadow_busy_idle_apply", int'(fcw_busy), 0);
      repeat (3) cyc();
      check_seq("shadow", '{130, 255, 125, 0, 130, 125, 130, 0}, 7);
      check_at("shadow_wrap_a", 4, 130, 1);
      check_at("shadow_wrap_b", 6, 130, 1);

      // sync_clr during an en step with a word pending.
      prog(16'h5000, 2);
      en = 1'b1; fcw_wr = 1'b1; fcw = 16'h1000; cyc(); fcw_wr = 1'b0;
      chk("sync_busy_before", int'(fcw_busy), 1);
      sync_clr = 1'b1; cyc(); sync_clr = 1'b0;
      chk("sync_busy_after", int'(fcw_busy), 0);
      repeat (2) cyc(); en = 1'b0; repeat (4) cyc();
      check_seq("sync", '{0, 80, 0, 16, 0, 0, 0, 0}, 4);
      check_at("sync_wrap", 2, 0, 1);
      check_at("sync_nowrap", 3, 16, 0);

      prog(0, 0);
      phase_off = 16'h8000; en = 1'b1; repeat (12) cyc(); en = 1'b0;
      check_seq("offset", '{125, 125, 125, 125, 125, 125, 125, 125}, 8);
      phase_off = '0;

      prog(16'h0100, 2);
      en = 1'b1; repeat (10) cyc();
      rst = 1'b1; cyc();
      chk("midrst_sample", int'(sample), 0);
      chk("midrst_valid", int'(sample_valid), 0);
      rst = 1'b0; clear_log();
      repeat (2) cyc();
      chk("midrst_no_stale", got_s.size(), 0);
      repeat (4) cyc(); en = 1'b0;
      check_seq("midrst_restart", '{0, 0, 0, 0, 0, 0, 0, 0}, 3);
      repeat (4) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
